mem_arbiter: RTL and testbench

Shared-memory arbiter for the multicore build. Sits between the per-core instruction and data cache request ports and the single RAM port, granting one request at a time. Data requests are prioritized over instruction fetches, and cores are served round-robin. A grant is held until RAM completes the access.

---
 rtl/mem_arbiter.sv | 140 ++++++++++++++
 tb/tb_mem_arbiter.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// +------------------------------------------------------------------------+
// | mem_arbiter: grants one core I/D cache port at a time to a single RAM.  |
// | Rev 1.0 - initial release                                               |
// +------------------------------------------------------------------------+
`default_nettype none

module mem_arbiter #(
  parameter int CPUS   = 2,
  parameter int WORD_W = 32
) (
  input  logic                          CLK,
  input  logic                          nRST,
  input  logic [CPUS-1:0]               iREN,
  input  logic [CPUS-1:0][WORD_W-1:0]   iaddr,
  output logic [CPUS-1:0]               iwait,
  output logic [CPUS-1:0][WORD_W-1:0]   iload,
  input  logic [CPUS-1:0]               dREN,
  input  logic [CPUS-1:0]               dWEN,
  input  logic [CPUS-1:0][WORD_W-1:0]   daddr,
  input  logic [CPUS-1:0][WORD_W-1:0]   dstore,
  output logic [CPUS-1:0]               dwait,
  output logic [CPUS-1:0][WORD_W-1:0]   dload,
  output logic                          ramREN,
  output logic                          ramWEN,
  output logic [WORD_W-1:0]             ramaddr,
  output logic [WORD_W-1:0]             ramstore,
  input  logic [WORD_W-1:0]             ramload,
  input  logic [1:0]                    ramstate
);

  localparam int         PTR_W        = (CPUS > 1) ? $clog2(CPUS) : 1;
  localparam logic [1:0] c_RAM_ACCESS = 2'd2;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t             r_state, w_state_nxt;
  logic [PTR_W-1:0]   r_gnt_core, w_gnt_core_nxt;
  logic               r_gnt_d, w_gnt_d_nxt;
  logic [PTR_W-1:0]   r_rr_ptr, w_rr_ptr_nxt;

  logic               w_d_hit, w_i_hit;
  logic [PTR_W-1:0]   w_d_core, w_i_core, w_idx;
  logic               w_g_req, w_done;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state    <= IDLE;
      r_gnt_core <= '0;
      r_gnt_d    <= 1'b0;
      r_rr_ptr   <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_gnt_core <= w_gnt_core_nxt;
      r_gnt_d    <= w_gnt_d_nxt;
      r_rr_ptr   <= w_rr_ptr_nxt;
    end
  end

  // First requesting port of each class, scanning from rr_ptr with wrap
  always_comb begin
    w_d_hit  = 1'b0;
    w_i_hit  = 1'b0;
    w_d_core = '0;
    w_i_core = '0;
    w_idx    = '0;
    for (int k = 0; k < CPUS; k++) begin
      w_idx = PTR_W'((int'(r_rr_ptr) + k) % CPUS);
      if (!w_d_hit && (dREN[w_idx] || dWEN[w_idx])) begin
        w_d_hit  = 1'b1;
        w_d_core = w_idx;
      end
      if (!w_i_hit && iREN[w_idx]) begin
        w_i_hit  = 1'b1;
        w_i_core = w_idx;
      end
    end
  end

  assign w_g_req = r_gnt_d ? (dREN[r_gnt_core] || dWEN[r_gnt_core]) : iREN[r_gnt_core];
  assign w_done  = (r_state == BUSY) && (ramstate == c_RAM_ACCESS);

  always_comb begin
    w_state_nxt    = r_state;
    w_gnt_core_nxt = r_gnt_core;
    w_gnt_d_nxt    = r_gnt_d;
    w_rr_ptr_nxt   = r_rr_ptr;
    ramREN         = 1'b0;
    ramWEN         = 1'b0;
    ramaddr        = '0;
    ramstore       = '0;
    iwait          = '1;
    dwait          = '1;
    case (r_state)
      IDLE: begin
        if (w_d_hit) begin
          w_state_nxt    = BUSY;
          w_gnt_core_nxt = w_d_core;
          w_gnt_d_nxt    = 1'b1;
        end else if (w_i_hit) begin
          w_state_nxt    = BUSY;
          w_gnt_core_nxt = w_i_core;
          w_gnt_d_nxt    = 1'b0;
        end
      end
      BUSY: begin
        if (w_g_req) begin
          if (r_gnt_d && dWEN[r_gnt_core]) begin
            ramWEN   = 1'b1;
            ramaddr  = daddr[r_gnt_core];
            ramstore = dstore[r_gnt_core];
          end else begin
            ramREN  = 1'b1;
            ramaddr = r_gnt_d ? daddr[r_gnt_core] : iaddr[r_gnt_core];
          end
        end
        // Completion outranks a same-cycle enable drop
        if (w_done) begin
          if (r_gnt_d) dwait[r_gnt_core] = 1'b0;
          else         iwait[r_gnt_core] = 1'b0;
          w_state_nxt  = IDLE;
          w_rr_ptr_nxt = PTR_W'((int'(r_gnt_core) + 1) % CPUS);
        end else if (!w_g_req) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  for (genvar g = 0; g < CPUS; g++) begin : g_load
    assign iload[g] = ramload;
    assign dload[g] = ramload;
  end

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
// +------------------------------------------------------------------------+
// | tb_mem_arbiter: random requesters against a priority-rank model.        |
// | Rev 1.0 - initial release                                               |
// +------------------------------------------------------------------------+
`default_nettype none

module tb_mem_arbiter;
  localparam int CPUS   = 2;
  localparam int WORD_W = 32;

  logic                        CLK = 1'b0;
  logic                        nRST;
  logic [CPUS-1:0]             iREN, iwait, dREN, dWEN, dwait;
  logic [CPUS-1:0][WORD_W-1:0] iaddr, iload, daddr, dstore, dload;
  logic                        ramREN, ramWEN;
  logic [WORD_W-1:0]           ramaddr, ramstore, ramload;
  logic [1:0]                  ramstate;

  mem_arbiter #(.CPUS(CPUS), .WORD_W(WORD_W)) dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dwait(dwait), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate)
  );

  always #5 CLK = ~CLK;

  int n_tests = 0;
  int n_fail  = 0;

  // Requester state and reference model state
  bit [CPUS-1:0]     pend_i, pend_d, done_i, done_d;
  int                d_kind [CPUS];
  logic [WORD_W-1:0] i_addr_q [CPUS];
  logic [WORD_W-1:0] d_addr_q [CPUS];
  logic [WORD_W-1:0] d_data_q [CPUS];
  bit                m_busy, m_d;
  int                m_core, m_ptr;

  task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic do_cycle(input bit allow_new, input int force_rs);
    logic              e_ren, e_wen;
    logic [WORD_W-1:0] e_addr, e_store;
    logic [CPUS-1:0]   e_iw, e_dw;
    bit                req, isd, best_d;
    int                best, brank, rank, r;
    req = 1'b0;
    @(negedge CLK);
    for (int c = 0; c < CPUS; c++) begin
      if (done_i[c]) pend_i[c] = 1'b0;
      if (done_d[c]) pend_d[c] = 1'b0;
      done_i[c] = 1'b0;
      done_d[c] = 1'b0;
      if (allow_new) begin
        if (pend_i[c] && $urandom_range(0, 39) == 0) pend_i[c] = 1'b0;
        else if (!pend_i[c] && $urandom_range(0, 2) == 0) begin
          pend_i[c]   = 1'b1;
          i_addr_q[c] = $urandom;
        end
        if (pend_d[c] && $urandom_range(0, 39) == 0) pend_d[c] = 1'b0;
        else if (!pend_d[c] && $urandom_range(0, 2) == 0) begin
          pend_d[c]   = 1'b1;
          d_kind[c]   = int'($urandom_range(0, 2));
          d_addr_q[c] = $urandom;
          d_data_q[c] = $urandom;
        end
      end
      iREN[c]   = pend_i[c];
      iaddr[c]  = pend_i[c] ? i_addr_q[c] : $urandom;
      dREN[c]   = pend_d[c] && (d_kind[c] != 1);
      dWEN[c]   = pend_d[c] && (d_kind[c] != 0);
      daddr[c]  = pend_d[c] ? d_addr_q[c] : $urandom;
      dstore[c] = pend_d[c] ? d_data_q[c] : $urandom;
    end
    if (force_rs >= 0) ramstate = 2'(force_rs);
    else begin
      r = int'($urandom_range(0, 9));
      ramstate = (r < 4) ? 2'd2 : (r < 7) ? 2'd1 : (r < 8) ? 2'd3 : 2'd0;
    end
    ramload = $urandom;
    #1;
    e_ren = 1'b0; e_wen = 1'b0; e_addr = '0; e_store = '0; e_iw = '1; e_dw = '1;
    if (m_busy) begin
      req = m_d ? (dREN[m_core] || dWEN[m_core]) : iREN[m_core];
      if (req) begin
        if (m_d && dWEN[m_core]) begin
          e_wen = 1'b1; e_addr = daddr[m_core]; e_store = dstore[m_core];
        end else begin
          e_ren = 1'b1; e_addr = m_d ? daddr[m_core] : iaddr[m_core];
        end
      end
      if (ramstate == 2'd2) begin
        if (m_d) e_dw[m_core] = 1'b0;
        else     e_iw[m_core] = 1'b0;
      end
    end
    check_value("ramREN", ramREN, e_ren);
    check_value("ramWEN", ramWEN, e_wen);
    check_value("ramaddr", ramaddr, e_addr);
    check_value("ramstore", ramstore, e_store);
    check_value("iwait", iwait, e_iw);
    check_value("dwait", dwait, e_dw);
    for (int c = 0; c < CPUS; c++) begin
      check_value("iload", iload[c], ramload);
      check_value("dload", dload[c], ramload);
      done_i[c] = !e_iw[c];
      done_d[c] = !e_dw[c];
    end
    @(posedge CLK);
    if (!m_busy) begin
      // Lowest rank wins: all D-ports rank below all I-ports, then distance from ptr
      best = -1; brank = 1 << 30; best_d = 1'b0;
      for (int c = 0; c < CPUS; c++) begin
        for (int cls = 0; cls < 2; cls++) begin
          isd = (cls == 0);
          if (isd ? (dREN[c] || dWEN[c]) : iREN[c]) begin
            rank = (isd ? 0 : CPUS) + ((c - m_ptr + CPUS) % CPUS);
            if (rank < brank) begin
              brank = rank; best = c; best_d = isd;
            end
          end
        end
      end
      if (best >= 0) begin
        m_busy = 1'b1; m_core = best; m_d = best_d;
      end
    end else if (ramstate == 2'd2) begin
      m_busy = 1'b0;
      m_ptr  = (m_core + 1) % CPUS;
    end else if (!req) begin
      m_busy = 1'b0;
    end
  endtask

  initial begin
    nRST = 1'b1;
    iREN = '0; dREN = '0; dWEN = '0;
    iaddr = '0; daddr = '0; dstore = '0;
    ramload = '0; ramstate = 2'd0;
    pend_i = '0; pend_d = '0; done_i = '0; done_d = '0;
    for (int c = 0; c < CPUS; c++) begin
      d_kind[c] = 0; i_addr_q[c] = '0; d_addr_q[c] = '0; d_data_q[c] = '0;
    end
    m_busy = 1'b0; m_d = 1'b0; m_core = 0; m_ptr = 0;
    #1 nRST = 1'b0;
    #1;
    check_value("rst_ramREN", ramREN, 1'b0);
    check_value("rst_ramWEN", ramWEN, 1'b0);
    check_value("rst_ramaddr", ramaddr, '0);
    check_value("rst_ramstore", ramstore, '0);
    check_value("rst_iwait", iwait, {CPUS{1'b1}});
    check_value("rst_dwait", dwait, {CPUS{1'b1}});
    repeat (2) @(negedge CLK);
    nRST = 1'b1;

    repeat (400) do_cycle(1'b1, -1);

    pend_i = '0; pend_d = '0;
    repeat (3) do_cycle(1'b0, 0);

    // Core0 read completes so rr_ptr moves to 1
    pend_d[0] = 1'b1; d_kind[0] = 0; d_addr_q[0] = 32'h300;
    do_cycle(1'b0, 2);
    do_cycle(1'b0, 2);
    do_cycle(1'b0, 0);

    // Core1 write, reset pulled while granted
    pend_d[1] = 1'b1; d_kind[1] = 1; d_addr_q[1] = 32'h400; d_data_q[1] = 32'hDEADBEEF;
    do_cycle(1'b0, 1);
    #2;
    check_value("pre_rst_ramWEN", ramWEN, 1'b1);
    check_value("pre_rst_ramstore", ramstore, 32'hDEADBEEF);
    nRST = 1'b0;
    iREN = '0; dREN = '0; dWEN = '0;
    #1;
    check_value("async_rst_ramWEN", ramWEN, 1'b0);
    check_value("async_rst_ramaddr", ramaddr, '0);
    check_value("async_rst_iwait", iwait, {CPUS{1'b1}});
    check_value("async_rst_dwait", dwait, {CPUS{1'b1}});
    pend_i = '0; pend_d = '0; done_i = '0; done_d = '0;
    m_busy = 1'b0; m_ptr = 0;
    @(negedge CLK);
    nRST = 1'b1;

    // Both cores read together: rr_ptr back at 0 means core0 first
    pend_d[0] = 1'b1; d_kind[0] = 0; d_addr_q[0] = 32'h500;
    pend_d[1] = 1'b1; d_kind[1] = 0; d_addr_q[1] = 32'h600;
    do_cycle(1'b0, 1);
    #1;
    check_value("rr_after_rst", ramaddr, 32'h500);
    repeat (4) do_cycle(1'b0, 2);

    repeat (60) do_cycle(1'b1, -1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
